// File: rtl/control_multiciclo_if.sv
// Control/status bundle between the multicycle control unit (master) and the datapath (slave).
// Carries decode inputs, memory handshake, every mux select/enable, and debug counters.
interface control_multiciclo_if #(
  parameter int ANCHO_CONT = 16
);
  logic [5:0]            opcode;
  logic                  oZero;
  logic                  MemListo;
  logic                  IoD;
  logic                  LeerMem;
  logic                  EscrMem;
  logic                  EscrIR;
  logic                  EscrPC;
  logic [1:0]            FuentePC;
  logic                  FuenteALUA;
  logic [1:0]            FuenteALUB;
  logic [1:0]            ALUOp;
  logic                  RegDest;
  logic                  MemaReg;
  logic                  EscrReg;
  logic                  Error;
  logic [3:0]            Estado;
  logic [ANCHO_CONT-1:0] NumInstr;

  modport master (
    input  opcode, oZero, MemListo,
    output IoD, LeerMem, EscrMem, EscrIR, EscrPC, FuentePC, FuenteALUA, FuenteALUB,
           ALUOp, RegDest, MemaReg, EscrReg, Error, Estado, NumInstr
  );

  modport slave (
    output opcode, oZero, MemListo,
    input  IoD, LeerMem, EscrMem, EscrIR, EscrPC, FuentePC, FuenteALUA, FuenteALUB,
           ALUOp, RegDest, MemaReg, EscrReg, Error, Estado, NumInstr
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/mem/writeback over a
// shared ALU and unified memory, stalling on MemListo; counts retired instructions.
module control_multiciclo #(
  parameter int ANCHO_CONT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  control_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11,
    ERROR    = 4'd12
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  estado_t               estado_q, estado_d;
  logic [ANCHO_CONT-1:0] num_q, num_d;
  logic                  error_q, error_d;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      FETCH:    if (bus.MemListo) estado_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: estado_d = MEMADR;
          OP_R:         estado_d = EXEC;
          OP_BEQ:       estado_d = BRANCH;
          OP_J:         estado_d = JUMP;
          OP_ADDI:      estado_d = ADDIEX;
          default:      estado_d = ERROR;
        endcase
      end
      MEMADR:   estado_d = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.MemListo) estado_d = MEMWB;
      MEMWB:    estado_d = FETCH;
      MEMWRITE: if (bus.MemListo) estado_d = FETCH;
      EXEC:     estado_d = ALUWB;
      ALUWB:    estado_d = FETCH;
      BRANCH:   estado_d = FETCH;
      JUMP:     estado_d = FETCH;
      ADDIEX:   estado_d = ADDIWB;
      ADDIWB:   estado_d = FETCH;
      ERROR:    estado_d = ERROR;
      default:  estado_d = ERROR;
    endcase
  end

  // Any entry into FETCH from another state is a retirement; ERROR and DECODE never reach FETCH.
  always_comb begin
    num_d   = num_q;
    error_d = error_q | (estado_d == ERROR);
    if (estado_q != FETCH && estado_d == FETCH) num_d = num_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= FETCH;
      num_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      num_q    <= num_d;
      error_q  <= error_d;
    end
  end

  logic       iod, leer, escr_mem, escr_ir, escr_pc, fuente_a, reg_dest, mema_reg, escr_reg;
  logic [1:0] fuente_pc, fuente_b, alu_op;

  always_comb begin
    iod       = 1'b0;
    leer      = 1'b0;
    escr_mem  = 1'b0;
    escr_ir   = 1'b0;
    escr_pc   = 1'b0;
    fuente_pc = 2'b00;
    fuente_a  = 1'b0;
    fuente_b  = 2'b00;
    alu_op    = 2'b00;
    reg_dest  = 1'b0;
    mema_reg  = 1'b0;
    escr_reg  = 1'b0;
    case (estado_q)
      FETCH: begin
        leer     = 1'b1;
        fuente_b = 2'b01;
        escr_ir  = bus.MemListo;
        escr_pc  = bus.MemListo;
      end
      DECODE:   fuente_b = 2'b11;
      MEMADR: begin
        fuente_a = 1'b1;
        fuente_b = 2'b10;
      end
      MEMREAD: begin
        iod  = 1'b1;
        leer = 1'b1;
      end
      MEMWB: begin
        mema_reg = 1'b1;
        escr_reg = 1'b1;
      end
      MEMWRITE: begin
        iod      = 1'b1;
        escr_mem = 1'b1;
      end
      EXEC: begin
        fuente_a = 1'b1;
        alu_op   = 2'b10;
      end
      ALUWB: begin
        reg_dest = 1'b1;
        escr_reg = 1'b1;
      end
      BRANCH: begin
        fuente_a  = 1'b1;
        alu_op    = 2'b01;
        fuente_pc = 2'b01;
        escr_pc   = bus.oZero;
      end
      JUMP: begin
        fuente_pc = 2'b10;
        escr_pc   = 1'b1;
      end
      ADDIEX: begin
        fuente_a = 1'b1;
        fuente_b = 2'b10;
      end
      ADDIWB:   escr_reg = 1'b1;
      default: ;
    endcase
  end

  // Write enables are masked by reset so an abandoned access or load cannot commit.
  assign bus.IoD        = iod;
  assign bus.LeerMem    = leer;
  assign bus.EscrMem    = escr_mem & ~reset;
  assign bus.EscrIR     = escr_ir & ~reset;
  assign bus.EscrPC     = escr_pc & ~reset;
  assign bus.FuentePC   = fuente_pc;
  assign bus.FuenteALUA = fuente_a;
  assign bus.FuenteALUB = fuente_b;
  assign bus.ALUOp      = alu_op;
  assign bus.RegDest    = reg_dest;
  assign bus.MemaReg    = mema_reg;
  assign bus.EscrReg    = escr_reg & ~reset;
  assign bus.Error      = error_q;
  assign bus.Estado     = estado_q;
  assign bus.NumInstr   = num_q;

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control unit for the 32-bit MIPS-subset datapath. It replaces single-cycle decode by sequencing each instruction through fetch, decode, execute, memory and write-back states over a shared ALU and a unified instruction/data memory. The memory has a ready handshake. The block drives every datapath mux select and write enable, and it counts retired instructions.

## Interface
Parameters:
- ANCHO_CONT, 16, width of the retired-instruction counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH and clears the counter
- opcode  input  6  instru[31:26] from the instruction register
- oZero  input  1  ALU zero flag
- MemListo  input  1  memory ready; the current access completes in a cycle where it is 1
- IoD  output  1  memory address select: 0 = PC, 1 = ALU result register
- LeerMem  output  1  memory read request
- EscrMem  output  1  memory write request
- EscrIR  output  1  instruction register load
- EscrPC  output  1  PC load (already resolved for branches)
- FuentePC  output  2  PC source: 00 = ALU, 01 = ALUOut (branch target), 10 = jump address
- FuenteALUA  output  1  ALU A: 0 = PC, 1 = register data1
- FuenteALUB  output  2  ALU B: 00 = data2, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct, 11 = reserved
- RegDest  output  1  write register: 0 = instru[20:16], 1 = instru[15:11]
- MemaReg  output  1  write data: 0 = ALUOut, 1 = memory data register
- EscrReg  output  1  register bank write enable
- Error  output  1  sticky illegal-opcode flag
- Estado  output  4  current state encoding, for debug
- NumInstr  output  ANCHO_CONT  retired-instruction count

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ERROR 12. Codes 13–15 go to ERROR.
- Default output value is 0 unless listed below for the current state.
- FETCH:
  - IoD=0, LeerMem=1, FuenteALUA=0, FuenteALUB=01, ALUOp=00, FuentePC=00.
  - EscrIR and EscrPC equal MemListo.
  - Stay in FETCH while MemListo=0; go to DECODE when it is 1.
- DECODE: FuenteALUA=0, FuenteALUB=11, ALUOp=00 (precompute the branch target). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - illegal → ERROR
- MEMADR: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: IoD=1, LeerMem=1. Wait for MemListo, then go to MEMWB.
- MEMWB: RegDest=0, MemaReg=1, EscrReg=1. Go to FETCH.
- MEMWRITE: IoD=1, EscrMem=1. Wait for MemListo, then go to FETCH.
- EXEC: FuenteALUA=1, FuenteALUB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegDest=1, MemaReg=0, EscrReg=1. Go to FETCH.
- BRANCH: FuenteALUA=1, FuenteALUB=00, ALUOp=01, FuentePC=01, EscrPC=oZero. Go to FETCH.
- JUMP: FuentePC=10, EscrPC=1. Go to FETCH.
- ADDIEX: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB: RegDest=0, MemaReg=0, EscrReg=1. Go to FETCH.
- ERROR: Error=1, all enables 0. Stays in ERROR until reset.
- NumInstr:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, JUMP or ADDIWB.
  - Wraps from all-ones to 0.
  - Does not count the FETCH→FETCH wait or illegal instructions.

## Timing
- Reset, asynchronous: state = FETCH, NumInstr = 0, Error = 0.
  - While reset=1, EscrPC, EscrIR, EscrReg and EscrMem are forced to 0.
  - The other outputs show their FETCH values: LeerMem=1, FuenteALUB=01, Estado=0.
- Latency with MemListo held at 1:
  - beq and j: 3 cycles
  - R-type, addi and sw: 4 cycles
  - lw: 5 cycles
- Each MemListo=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- Handshake:
  - LeerMem and EscrMem stay asserted and stable until the cycle MemListo=1.
  - The state advances on the clock edge ending that cycle.
  - MemListo is ignored in all other states.
- EscrIR, EscrPC (in FETCH and BRANCH) and EscrReg are single-cycle pulses.
- The register file and PC sample these pulses on the same rising edge that advances the state.
- Reset asserted mid-instruction (for example in MEMWRITE with EscrMem=1): EscrMem drops immediately (combinationally) and the in-flight access is abandoned.
- After reset releases, the first rising edge evaluates FETCH.

## Test plan
- Reset, then R-type (opcode 000000) with MemListo=1 → Estado sequence 0,1,6,7,0; EscrReg=1 and RegDest=1 only in state 7; NumInstr goes 0→1.
- lw (100011) with MemListo low for 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total; LeerMem stays high throughout each wait; EscrIR pulses exactly once; MemaReg=1 and EscrReg=1 in MEMWB.
- beq (000100) with oZero=1, then beq with oZero=0 → EscrPC=1 with FuentePC=01 in BRANCH for the first; EscrPC=0 for the second; both take 3 cycles; NumInstr +2.
- j (000010), then sw (101011) → JUMP asserts EscrPC=1 with FuentePC=10; sw asserts IoD=1 and EscrMem=1 in MEMWRITE; EscrReg is never asserted.
- Opcode 111111 → Estado 1, then 12; Error=1 held for 20 cycles; no enables asserted; NumInstr unchanged. Reset then clears Error and returns to FETCH.
- Preload NumInstr near wrap (ANCHO_CONT=4) and run 16 addi (001000) instructions → count wraps 15→0; each addi takes 4 cycles and asserts EscrReg in ADDIWB with RegDest=0.
